// File: rtl/sincos_pkg.sv
// Shared definitions for the sine/cosine phase-sequence generator.
// Contents:
//   state_t  - run-control FSM states (IDLE, RUN)
//   PHASE_W  - default phase/frequency word width (one turn = full scale)
//   COUNT_W  - default sample-count width
//   RATE_W   - default rate-divider width
package sincos_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PHASE_W = 32;
    localparam int COUNT_W = 16;
    localparam int RATE_W  = 16;

endpackage

// File: rtl/sincos_phase_gen_if.sv
// Control/data bundle between a run controller and the phase generator.
// master: drives run parameters and start/stop, observes the phase stream.
// slave : the generator; receives run parameters, drives phase_o, valid_o,
//         mode_cos_o, busy_o and done_o.
interface sincos_phase_gen_if
    import sincos_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_W,
    parameter int COUNT_WIDTH = COUNT_W,
    parameter int RATE_WIDTH  = RATE_W
);
    logic                   start_i;
    logic                   stop_i;
    logic [PHASE_WIDTH-1:0] freq_i;
    logic [PHASE_WIDTH-1:0] step_i;
    logic [PHASE_WIDTH-1:0] offset_i;
    logic [COUNT_WIDTH-1:0] count_i;
    logic [RATE_WIDTH-1:0]  rate_i;
    logic                   mode_cos_i;
    logic [PHASE_WIDTH-1:0] phase_o;
    logic                   valid_o;
    logic                   mode_cos_o;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output start_i, stop_i, freq_i, step_i, offset_i, count_i, rate_i, mode_cos_i,
        input  phase_o, valid_o, mode_cos_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, freq_i, step_i, offset_i, count_i, rate_i, mode_cos_i,
        output phase_o, valid_o, mode_cos_o, busy_o, done_o
    );
endinterface

// File: rtl/sincos_phase_acc.sv
// Phase accumulator with chirped tuning word.
// Ports:
//   clk, resetn          - clock, async active-low reset
//   load                 - take offset/freq/step as the new run state
//   advance              - phase += freq, freq += step (both modular)
//   offset, freq, step   - values captured on load
//   phase                - registered phase word
module sincos_phase_acc #(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic                   advance,
    input  logic [PHASE_WIDTH-1:0] offset,
    input  logic [PHASE_WIDTH-1:0] freq,
    input  logic [PHASE_WIDTH-1:0] step,
    output logic [PHASE_WIDTH-1:0] phase
);
    logic [PHASE_WIDTH-1:0] phase_r;
    logic [PHASE_WIDTH-1:0] freq_r;
    logic [PHASE_WIDTH-1:0] step_r;

    // Phase/frequency state; the phase add uses freq_r before its own update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_r <= '0;
            freq_r  <= '0;
            step_r  <= '0;
        end else if (load) begin
            phase_r <= offset;
            freq_r  <= freq;
            step_r  <= step;
        end else if (advance) begin
            phase_r <= phase_r + freq_r;
            freq_r  <= freq_r + step_r;
        end else begin
            phase_r <= phase_r;
            freq_r  <= freq_r;
            step_r  <= step_r;
        end
    end

    assign phase = phase_r;
endmodule

// File: rtl/sincos_phase_gen.sv
// Phase-sequence generator feeding sincos_linear (phase_i/valid_i/mode_cos).
// Produces bursts (count_i samples) or continuous streams (count_i = 0) of
// NCO or linear-chirp phase words, one sample every rate_i+1 cycles.
// Ports:
//   clk, resetn - clock, async active-low reset
//   bus         - slave side of sincos_phase_gen_if (run parameters in,
//                 phase_o/valid_o/mode_cos_o/busy_o/done_o out, all registered)
module sincos_phase_gen
    import sincos_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_W,
    parameter int COUNT_WIDTH = COUNT_W,
    parameter int RATE_WIDTH  = RATE_W
) (
    input  logic              clk,
    input  logic              resetn,
    sincos_phase_gen_if.slave bus
);
    state_t                 state_r, state_s;
    logic [COUNT_WIDTH-1:0] cnt_r, cnt_s;
    logic [COUNT_WIDTH-1:0] samp_r, samp_s;
    logic [RATE_WIDTH-1:0]  rate_r, rate_s;
    logic [RATE_WIDTH-1:0]  div_r, div_s;
    logic                   valid_r, valid_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   mode_r, mode_s;
    logic                   load_s;
    logic                   adv_s;
    logic [PHASE_WIDTH-1:0] phase_s;

    // Next-state, counter/divider and output decisions.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        samp_s  = samp_r;
        rate_s  = rate_r;
        div_s   = div_r;
        mode_s  = mode_r;
        busy_s  = busy_r;
        valid_s = 1'b0;
        done_s  = 1'b0;
        load_s  = 1'b0;
        adv_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // stop wins over a simultaneous start
                if (bus.start_i && !bus.stop_i) begin
                    state_s = RUN;
                    load_s  = 1'b1;
                    cnt_s   = bus.count_i;
                    rate_s  = bus.rate_i;
                    mode_s  = bus.mode_cos_i;
                    valid_s = 1'b1;
                    samp_s  = COUNT_WIDTH'(1'b1);
                    div_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else if ((cnt_r != '0) && (samp_r == cnt_r)) begin
                    // last sample went out on the previous cycle
                    state_s = IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else if (div_r == rate_r) begin
                    adv_s   = 1'b1;
                    valid_s = 1'b1;
                    samp_s  = samp_r + COUNT_WIDTH'(1'b1);
                    div_s   = '0;
                end else begin
                    div_s   = div_r + RATE_WIDTH'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Control registers and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            samp_r  <= '0;
            rate_r  <= '0;
            div_r   <= '0;
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            samp_r  <= samp_s;
            rate_r  <= rate_s;
            div_r   <= div_s;
            mode_r  <= mode_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    sincos_phase_acc #(
        .PHASE_WIDTH(PHASE_WIDTH)
    ) u_acc (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load_s),
        .advance (adv_s),
        .offset  (bus.offset_i),
        .freq    (bus.freq_i),
        .step    (bus.step_i),
        .phase   (phase_s)
    );

    assign bus.phase_o    = phase_s;
    assign bus.valid_o    = valid_r;
    assign bus.mode_cos_o = mode_r;
    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
endmodule

// File: doc/sincos_phase_gen.md
# sincos_phase_gen

Phase-sequence generator that drives the `phase_i` / `valid_i` / `mode_cos` inputs of `sincos_linear`. It produces a burst or continuous stream of phase words: fixed-frequency (NCO) or linear chirp, with a programmable phase offset and sample-rate divider. It replaces hand-driven phase stimulus in front of the sine/cosine core, both in the Fmax harness and in system use.

## Interface
Parameters:
- `PHASE_WIDTH`, 32: phase/frequency word width; full scale = one turn.
- `COUNT_WIDTH`, 16: sample-count width.
- `RATE_WIDTH`, 16: rate-divider width.

Ports (clock and reset first). Reset is asynchronous and active-low; single clock domain.
- `clk` in 1: single clock; all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start_i` in 1: start a run. Sampled only when `busy_o`=0.
- `stop_i` in 1: abort the current run.
- `freq_i` in PHASE_WIDTH: initial tuning word. Sampled at start.
- `step_i` in PHASE_WIDTH: two's-complement chirp increment per sample. Sampled at start.
- `offset_i` in PHASE_WIDTH: phase of the first sample. Sampled at start.
- `count_i` in COUNT_WIDTH: samples per run. 0 = continuous. Sampled at start.
- `rate_i` in RATE_WIDTH: one sample every `rate_i`+1 cycles. Sampled at start.
- `mode_cos_i` in 1: cos/sin select. Latched at start.
- `phase_o` out PHASE_WIDTH: phase word, connects to `sincos_linear.phase_i`.
- `valid_o` out 1: phase strobe, connects to `valid_i`.
- `mode_cos_o` out 1: latched mode, connects to `mode_cos`.
- `busy_o` out 1: run in progress.
- `done_o` out 1: one-cycle pulse at end of run (completed or aborted).

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN on `start_i`=1 and `stop_i`=0.
  - Load `freq_r`, `step_r`, `cnt`, `rate_r` and `mode_cos_o`.
  - Emit the first sample immediately: `phase_o`←`offset_i`, `valid_o`←1, sample count←1, divider←0.
- RUN, sample due when divider = `rate_r`:
  - `phase_o`←`phase_o`+`freq_r` (mod 2^PHASE_WIDTH), using `freq_r` before its update.
  - `freq_r`←`freq_r`+`step_r` (mod 2^PHASE_WIDTH).
  - `valid_o`←1, count+1, divider←0.
- RUN, sample not due: divider+1, `valid_o`←0, `phase_o` holds.
- RUN → IDLE (completion):
  - On the edge after the cycle whose `valid_o` carried sample number `count_i` (`count_i`≠0).
  - That edge sets `done_o`←1, `busy_o`←0, `valid_o`←0.
- `count_i`=0: run continues until `stop_i`.
- `stop_i`=1 in RUN:
  - Next edge goes to IDLE, sets `valid_o`←0 (even if a sample was due), `done_o`←1, `busy_o`←0.
  - `phase_o` holds its last value.
- `stop_i`=1 in IDLE: no effect, no `done_o`. If `start_i` and `stop_i` are both high in IDLE, stop wins and no run starts.
- `start_i` while `busy_o`=1: ignored.
- A start accepted in the cycle `done_o`=1 is legal (back-to-back runs). No gap is required.
- Wrap-around is modular, with no saturation. Negative `step_i` lowers frequency, and the frequency may cross zero.

## Timing
- Reset values: `phase_o`=0, `valid_o`=0, `mode_cos_o`=0, `busy_o`=0, `done_o`=0, FSM=IDLE. Internal registers are also cleared.
- Reset mid-run: outputs return to the reset values asynchronously. No `done_o` is issued.
- All outputs are registered; none has a combinational path from the inputs.
- Latency from `start_i` sampled at edge E to:
  - `valid_o`=1 for the first sample: the cycle after E.
  - Sample k (0-based): the cycle after E + k·(`rate_i`+1).
  - `done_o`: the cycle after E + (`count_i`−1)·(`rate_i`+1) + 1.
- `busy_o` is 1 from the cycle after E through the cycle of the last `valid_o`.
- `rate_i`=0 gives `valid_o` continuously high for the whole run.

## Structure
- Package `sincos_pkg`:
  - State enum {IDLE, RUN}.
  - Default width constants `PHASE_W`=32, `COUNT_W`=16, `RATE_W`=16.
- One sub-module, `sincos_phase_acc`:
  - Phase and frequency registers with their two modular adders.
  - Controls: load and advance enables.
  - Parameterised by PHASE_WIDTH.
- FSM, sample counter and rate divider stay in the top module.

## Test plan
1. `freq`=0x1000_0000, `offset`=0, `step`=0, `count`=4, `rate`=0 → `valid_o` high for 4 consecutive cycles with `phase_o` 0x0, 0x1000_0000, 0x2000_0000, 0x3000_0000. The next cycle has `done_o`=1 and `busy_o`=0.
2. Wrap: `offset`=0xF000_0000, `freq`=0x2000_0000, `count`=3 → phases 0xF000_0000, 0x1000_0000, 0x3000_0000.
3. Divider: `rate`=2, `count`=3, start at edge E → `valid_o` in cycles E+1, E+4, E+7 only. `done_o` in cycle E+8.
4. Chirp: `offset`=0, `freq`=0x100, `step`=0x10, `count`=4 → phases 0x0, 0x100, 0x210, 0x330. Repeat with `step`=0xFFFF_FFF0 → 0x0, 0x100, 0x1F0, 0x2D0.
5. Continuous run (`count`=0, `rate`=0); pulse `start_i` during the run; assert `stop_i` after the 10th sample → the start is ignored. Exactly 10 `valid_o` pulses, then `done_o` on the next edge. Then `start_i`+`stop_i` together in IDLE → no run.
6. Reset mid-run after sample 2, `mode_cos_i`=1 → all outputs 0 immediately, no `done_o`. A new start with `offset`=0x1234 gives a first phase of 0x1234 with `mode_cos_o`=1.
